dmem_arbiter: RTL and testbench

- Two-port round-robin arbiter and access sequencer in front of the single-port data memory (AWIDTH x ALENGTH words, word-indexed, word 0 hardwired to zero).
- Port 0 is the core load/store unit. Port 1 is the debug/program-loader port.
- Serialises accesses through a 3-state FSM, registers all memory-side drive, returns registered read data with a valid pulse, and flags out-of-range addresses.

---
 rtl/dmem_arbiter.sv | 247 ++++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port round-robin arbiter and access sequencer in front of
//                a single-port, word-indexed data memory whose word 0 reads
//                as zero.
//                Port 0 is the core load/store unit. Port 1 is the
//                debug/program-loader port.
//                Each accepted request runs through a fixed IDLE -> ACCESS ->
//                RESP sequence:
//                  - grant in IDLE (combinational)
//                  - memory drive in ACCESS
//                  - rvalid pulse in RESP
//                so at most one access completes every three cycles.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n                 : clock (rising edge), async active-low reset
//    i_pN_req                   : access request, held until o_pN_gnt
//    i_pN_we                    : 1 = write, 0 = read
//    i_pN_addr, i_pN_wdata      : word index and write data
//    o_pN_gnt                   : one-cycle accept pulse (fields sampled here)
//    o_pN_rvalid                : one-cycle completion pulse (reads & writes)
//    o_pN_rdata, o_pN_err       : read data / out-of-range flag, valid with
//                                 o_pN_rvalid, held until the next completion
//    o_mem_we, o_mem_addr,
//    o_mem_wdata                : registered memory-side drive
//    i_mem_rdata                : memory read data, combinational from addr
//    o_busy                     : high whenever the sequencer is not IDLE
// ============================================================================
module dmem_arbiter #(
    parameter int AWIDTH  = 32,
    parameter int ALENGTH = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    // port 0 : load/store unit
    input  logic              i_p0_req,
    input  logic              i_p0_we,
    input  logic [AWIDTH-1:0] i_p0_addr,
    input  logic [AWIDTH-1:0] i_p0_wdata,
    output logic              o_p0_gnt,
    output logic              o_p0_rvalid,
    output logic [AWIDTH-1:0] o_p0_rdata,
    output logic              o_p0_err,
    // port 1 : debug / program loader
    input  logic              i_p1_req,
    input  logic              i_p1_we,
    input  logic [AWIDTH-1:0] i_p1_addr,
    input  logic [AWIDTH-1:0] i_p1_wdata,
    output logic              o_p1_gnt,
    output logic              o_p1_rvalid,
    output logic [AWIDTH-1:0] o_p1_rdata,
    output logic              o_p1_err,
    // memory side
    output logic              o_mem_we,
    output logic [AWIDTH-1:0] o_mem_addr,
    output logic [AWIDTH-1:0] o_mem_wdata,
    input  logic [AWIDTH-1:0] i_mem_rdata,
    // status
    output logic              o_busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    // Memory size at full address width: the range check must see every
    // address bit, so e.g. 0x8000_0000 is out of range rather than aliasing.
    localparam logic [AWIDTH-1:0] c_ALENGTH = AWIDTH'(ALENGTH);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_next_state;

    logic              r_last_grant;  // port that won the previous arbitration
    logic              r_port;        // port that owns the in-flight access
    logic [AWIDTH-1:0] r_addr;
    logic [AWIDTH-1:0] r_wdata;
    logic              r_mem_we;

    logic              r_p0_rvalid;
    logic              r_p1_rvalid;
    logic [AWIDTH-1:0] r_p0_rdata;
    logic [AWIDTH-1:0] r_p1_rdata;
    logic              r_p0_err;
    logic              r_p1_err;

    logic              w_any_req;
    logic              w_win;         // winning port id (0 or 1)
    logic              w_accept;      // a request is accepted this cycle
    logic              w_win_we;
    logic [AWIDTH-1:0] w_win_addr;
    logic [AWIDTH-1:0] w_win_wdata;
    logic              w_win_writable;
    logic              w_addr_oor;
    logic [AWIDTH-1:0] w_access_rdata;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    assign w_any_req = i_p0_req | i_p1_req;

    // A lone requester wins outright. On a tie, the port that did not win
    // last time is chosen. r_last_grant resets to 1, so port 0 wins the
    // first tie after reset.
    assign w_win = (i_p0_req & i_p1_req) ? ~r_last_grant : i_p1_req;

    assign w_accept    = (r_state == c_IDLE) & w_any_req;
    assign w_win_we    = w_win ? i_p1_we    : i_p0_we;
    assign w_win_addr  = w_win ? i_p1_addr  : i_p0_addr;
    assign w_win_wdata = w_win ? i_p1_wdata : i_p0_wdata;

    // Word 0 is read-only zero and out-of-range words do not exist, so
    // neither may ever see a write strobe.
    assign w_win_writable = w_win_we
                          & (w_win_addr != '0)
                          & (w_win_addr < c_ALENGTH);

    // Range check of the latched address, evaluated during ACCESS.
    assign w_addr_oor = (r_addr >= c_ALENGTH);

    // An out-of-range access returns zero, whatever the memory drives.
    assign w_access_rdata = w_addr_oor ? '0 : i_mem_rdata;

    // ------------------------------------------------------------------------
    // FSM : state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM : next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:   if (w_any_req) w_next_state = c_ACCESS;
            c_ACCESS: w_next_state = c_RESP;
            c_RESP:   w_next_state = c_IDLE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM : outputs
    // Grants are combinational so a requester sees its accept in the same
    // cycle it is chosen. w_accept already contains the IDLE condition.
    // ------------------------------------------------------------------------
    always_comb begin
        o_p0_gnt = 1'b0;
        o_p1_gnt = 1'b0;
        o_busy   = (r_state != c_IDLE);
        if (w_accept) begin
            o_p0_gnt = ~w_win;
            o_p1_gnt =  w_win;
        end
    end

    // ------------------------------------------------------------------------
    // Request capture and memory-side drive
    // Address and data are latched on the accept edge and left untouched
    // afterwards, so the memory bus holds its last value outside ACCESS.
    // The write strobe is decided on the accept edge and cleared on the
    // ACCESS exit edge, so it is high for exactly the ACCESS cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_we     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_win;
                r_port       <= w_win;
                r_addr       <= w_win_addr;
                r_wdata      <= w_win_wdata;
                r_mem_we     <= w_win_writable;
            end else if (r_state == c_ACCESS) begin
                r_mem_we     <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response path
    // Read data is sampled at the end of ACCESS, on the same edge that
    // commits any write. A write therefore returns the word's previous
    // contents. The rvalid pulse spans the RESP cycle only.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
            r_p0_err    <= 1'b0;
            r_p1_err    <= 1'b0;
        end else begin
            case (r_state)
                c_ACCESS: begin
                    if (r_port == 1'b0) begin
                        r_p0_rvalid <= 1'b1;
                        r_p0_rdata  <= w_access_rdata;
                        r_p0_err    <= w_addr_oor;
                    end else begin
                        r_p1_rvalid <= 1'b1;
                        r_p1_rdata  <= w_access_rdata;
                        r_p1_err    <= w_addr_oor;
                    end
                end
                default: begin
                    r_p0_rvalid <= 1'b0;
                    r_p1_rvalid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;

    assign o_p0_rvalid = r_p0_rvalid;
    assign o_p1_rvalid = r_p1_rvalid;
    assign o_p0_rdata  = r_p0_rdata;
    assign o_p1_rdata  = r_p1_rdata;
    assign o_p0_err    = r_p0_err;
    assign o_p1_err    = r_p1_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed self-checking bench for dmem_arbiter with a
//                behavioural 128-word memory (word 0 reads zero, addresses
//                past the end return a junk pattern).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int AL = 128;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;

    logic          p0_req = 1'b0, p0_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p0_wdata = '0;
    logic          p0_gnt, p0_rvalid, p0_err;
    logic [AW-1:0] p0_rdata;

    logic          p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p1_addr = '0, p1_wdata = '0;
    logic          p1_gnt, p1_rvalid, p1_err;
    logic [AW-1:0] p1_rdata;

    logic          mem_we, busy;
    logic [AW-1:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AWIDTH(AW), .ALENGTH(AL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_p0_req    (p0_req),
        .i_p0_we     (p0_we),
        .i_p0_addr   (p0_addr),
        .i_p0_wdata  (p0_wdata),
        .o_p0_gnt    (p0_gnt),
        .o_p0_rvalid (p0_rvalid),
        .o_p0_rdata  (p0_rdata),
        .o_p0_err    (p0_err),
        .i_p1_req    (p1_req),
        .i_p1_we     (p1_we),
        .i_p1_addr   (p1_addr),
        .i_p1_wdata  (p1_wdata),
        .o_p1_gnt    (p1_gnt),
        .o_p1_rvalid (p1_rvalid),
        .o_p1_rdata  (p1_rdata),
        .o_p1_err    (p1_err),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .o_busy      (busy)
    );

    // ------------------------------------------------------------------------
    // Memory model. Preloaded on the first clock edge (during reset).
    // ------------------------------------------------------------------------
    logic [AW-1:0] mem [0:AL-1];
    bit            loaded = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < AL; i++) mem[i] <= '0;
            mem[5]   <= 32'hDEADBEEF;
            mem[7]   <= 32'h11111111;
            mem[9]   <= 32'h99999999;
            mem[127] <= 32'h7F7F7F7F;
            loaded   <= 1'b1;
        end else if (mem_we && mem_addr < AL && mem_addr != 0) begin
            mem[mem_addr[6:0]] <= mem_wdata;
        end
    end

    always_comb begin
        if (mem_addr >= AL)     mem_rdata = 32'hBAD0BAD0;
        else if (mem_addr == 0) mem_rdata = '0;
        else                    mem_rdata = mem[mem_addr[6:0]];
    end

    // ------------------------------------------------------------------------
    // Driver: one transaction on one port. Returns observations only.
    //   gnt_wait : cycles from request to grant (-1 = never)
    //   lat      : cycles from grant to rvalid  (-1 = never)
    // ------------------------------------------------------------------------
    task automatic xact(input int port, input logic we,
                        input logic [AW-1:0] addr, input logic [AW-1:0] wdata,
                        output int gnt_wait, output int lat,
                        output logic [AW-1:0] rdata, output logic err,
                        output int we_pulses, output logic [AW-1:0] acc_addr,
                        output logic busy_ok, output logic other_valid);
        logic g;
        gnt_wait = -1; lat = -1; rdata = '0; err = 1'b0; we_pulses = 0;
        acc_addr = '0; busy_ok = 1'b1; other_valid = 1'b0;
        @(posedge clk); #1;
        if (port == 0) begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            g = (port == 0) ? p0_gnt : p1_gnt;
            if (g) begin gnt_wait = i; break; end
        end
        @(posedge clk); #1;
        if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
        if (gnt_wait < 0) return;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (mem_we) we_pulses++;
            if (i == 1) acc_addr = mem_addr;
            if (i <= 2 && !busy) busy_ok = 1'b0;
            if ((port == 0) ? p1_rvalid : p0_rvalid) other_valid = 1'b1;
            if ((port == 0) ? p0_rvalid : p1_rvalid) begin
                lat   = i;
                rdata = (port == 0) ? p0_rdata : p1_rdata;
                err   = (port == 0) ? p0_err : p1_err;
                break;
            end
        end
    endtask

    int            gw, lt, wp;
    logic [AW-1:0] rd, aa;
    logic          er, bo, ov;

    // ------------------------------------------------------------------------
    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_we, busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_we, busy});
        end
        checks++;
        if ({p0_rdata, p1_rdata, mem_addr, mem_wdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h want all zero",
                     p0_rdata, p1_rdata, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_p0_read();
        xact(0, 1'b0, 32'd5, 32'h0, gw, lt, rd, er, wp, aa, bo, ov);
        checks++; if (gw !== 0) begin errors++; $display("FAIL p0rd_gnt_wait: got %0d want 0", gw); end
        checks++; if (aa !== 32'd5) begin errors++; $display("FAIL p0rd_mem_addr: got %h want 5", aa); end
        checks++; if (lt !== 2) begin errors++; $display("FAIL p0rd_latency: got %0d want 2", lt); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL p0rd_rdata: got %h want deadbeef", rd); end
        checks++; if ({er, wp != 0, ov} !== 3'b000) begin errors++; $display("FAIL p0rd_err_we_other: got %b want 000", {er, wp != 0, ov}); end
        checks++; if (bo !== 1'b1) begin errors++; $display("FAIL p0rd_busy: got %b want 1", bo); end
        @(negedge clk);
        checks++;
        if ({busy, p0_rvalid} !== 2'b00 || p0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL p0rd_after: got busy/rvalid %b rdata %h want 00 deadbeef", {busy, p0_rvalid}, p0_rdata);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_p1_write_read();
        xact(1, 1'b1, 32'd7, 32'h12345678, gw, lt, rd, er, wp, aa, bo, ov);
        checks++; if (wp !== 1) begin errors++; $display("FAIL p1wr_we_pulses: got %0d want 1", wp); end
        checks++; if (aa !== 32'd7) begin errors++; $display("FAIL p1wr_mem_addr: got %h want 7", aa); end
        checks++; if (rd !== 32'h11111111 || er !== 1'b0 || lt !== 2) begin
            errors++; $display("FAIL p1wr_resp: got rdata %h err %b lat %0d want 11111111 0 2", rd, er, lt); end
        checks++; if (mem[7] !== 32'h12345678) begin errors++; $display("FAIL p1wr_mem7: got %h want 12345678", mem[7]); end
        xact(1, 1'b0, 32'd7, 32'h0, gw, lt, rd, er, wp, aa, bo, ov);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL p1rd_rdata: got %h want 12345678", rd); end
        checks++; if (p0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL p0_rdata_hold: got %h want deadbeef", p0_rdata); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_word0();
        xact(0, 1'b1, 32'd0, 32'hFFFFFFFF, gw, lt, rd, er, wp, aa, bo, ov);
        checks++; if (wp !== 0) begin errors++; $display("FAIL w0_we_pulses: got %0d want 0", wp); end
        checks++; if (lt !== 2 || er !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL w0_resp: got lat %0d err %b rdata %h want 2 0 0", lt, er, rd); end
        xact(1, 1'b0, 32'd0, 32'h0, gw, lt, rd, er, wp, aa, bo, ov);
        checks++; if (rd !== 32'h0 || lt !== 2) begin errors++; $display("FAIL w0_readback: got %h lat %0d want 0 2", rd, lt); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_out_of_range();
        xact(1, 1'b0, 32'd128, 32'h0, gw, lt, rd, er, wp, aa, bo, ov);
        checks++; if (er !== 1'b1 || rd !== 32'h0 || lt !== 2) begin
            errors++; $display("FAIL oor_rd128: got err %b rdata %h lat %0d want 1 0 2", er, rd, lt); end
        xact(0, 1'b1, 32'h80000000, 32'hA5A5A5A5, gw, lt, rd, er, wp, aa, bo, ov);
        checks++; if (er !== 1'b1 || rd !== 32'h0 || wp !== 0) begin
            errors++; $display("FAIL oor_wr_hi: got err %b rdata %h we %0d want 1 0 0", er, rd, wp); end
        xact(0, 1'b0, 32'd127, 32'h0, gw, lt, rd, er, wp, aa, bo, ov);
        checks++; if (er !== 1'b0 || rd !== 32'h7F7F7F7F) begin
            errors++; $display("FAIL edge_rd127: got err %b rdata %h want 0 7f7f7f7f", er, rd); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_round_robin();
        int g_port[$];
        int g_cyc[$];
        int dbl;
        int exp_port[4];
        int exp_cyc[4];
        exp_port = '{0, 1, 0, 1};
        exp_cyc  = '{0, 3, 6, 9};
        dbl = 0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd5;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'd7;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (p0_gnt && p1_gnt) dbl++;
            if (p0_gnt) begin g_port.push_back(0); g_cyc.push_back(i); end
            if (p1_gnt) begin g_port.push_back(1); g_cyc.push_back(i); end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (dbl !== 0) begin errors++; $display("FAIL rr_double_grant: got %0d want 0", dbl); end
        checks++; if (g_port.size() !== 4) begin errors++; $display("FAIL rr_grant_count: got %0d want 4", g_port.size()); end
        for (int i = 0; i < 4 && i < g_port.size(); i++) begin
            checks++;
            if (g_port[i] !== exp_port[i] || g_cyc[i] !== exp_cyc[i]) begin
                errors++;
                $display("FAIL rr_grant%0d: got port %0d cycle %0d want port %0d cycle %0d",
                         i, g_port[i], g_cyc[i], exp_port[i], exp_cyc[i]);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid();
        int gcyc;
        int rv;
        gcyc = -1;
        rv = 0;
        @(posedge clk); #1;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'd9; p1_wdata = 32'hCAFEF00D;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p1_gnt) begin gcyc = i; break; end
        end
        checks++; if (gcyc !== 0) begin errors++; $display("FAIL rm_gnt_wait: got %0d want 0", gcyc); end
        @(posedge clk); #1;
        p1_req = 1'b0;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rm_access_we: got %b want 1", mem_we); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_we, busy, p1_rvalid} !== 3'b000 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rm_async_clear: got we/busy/rvalid %b addr %h want 000 0", {mem_we, busy, p1_rvalid}, mem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (p1_rvalid) rv++;
        end
        checks++; if (rv !== 0) begin errors++; $display("FAIL rm_no_rvalid: got %0d want 0", rv); end
        checks++; if (mem[9] !== 32'h99999999) begin errors++; $display("FAIL rm_word9: got %h want 99999999", mem[9]); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd5;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'd7;
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            errors++; $display("FAIL rm_first_grant: got p0/p1 %b want 10", {p0_gnt, p1_gnt});
        end
        @(posedge clk); #1;
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    initial begin
        test_reset();
        test_p0_read();
        test_p1_write_read();
        test_word0();
        test_out_of_range();
        test_round_robin();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
